tdc_tap_decoder: RTL

TDC_TAP_DECODER -- requirements
Module: tdc_tap_decoder

---
 rtl/tdc_tap_decoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/tdc_tap_decoder.sv
// TDC tap decoder: 2-flop tap capture, popcount fine code, edge-arming hit FSM, one-entry timestamp register.
// Hit to ts_valid in 2 cycles; hits that find the register full and not being read are dropped and counted.
module tdc_tap_decoder #(
  parameter int TAPS     = 32,
  parameter int FINE_W   = 6,
  parameter int COARSE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [TAPS-1:0]            taps,
  output logic [COARSE_W+FINE_W-1:0] ts_data,
  output logic                       ts_valid,
  input  logic                       ts_ready,
  output logic [7:0]                 drop_count
);

  typedef struct packed {
    logic [COARSE_W-1:0] coarse;
    logic [FINE_W-1:0]   fine;
  } ts_t;

  typedef enum logic [1:0] {IDLE, ARMED, WAIT_LOW} state_t;

  logic [TAPS-1:0]     s1, s2;
  logic                s1_vld, s2_vld;
  logic [COARSE_W-1:0] cnt, c2;
  logic [FINE_W-1:0]   fine;
  state_t              state, state_nxt;
  logic                s2_zero, hit, load, drop;
  ts_t                 ts_q;

  // c2 samples the counter one edge after s1 loaded, i.e. the value held right after that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      cnt    <= '0;
      c2     <= '0;
    end else begin
      s1     <= taps;
      s2     <= s1;
      s1_vld <= 1'b1;
      s2_vld <= s1_vld;
      cnt    <= cnt + COARSE_W'(1);
      c2     <= cnt;
    end
  end

  always_comb begin
    fine = '0;
    for (int i = 0; i < TAPS; i++) begin
      fine = fine + FINE_W'(s2[i]);
    end
  end

  // Reset-filled zeros in s1/s2 are not real samples, so they must not arm the detector.
  assign s2_zero = s2_vld && (s2 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    case (state)
      IDLE: begin
        if (enable && s2_zero) state_nxt = ARMED;
      end
      ARMED: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (s2[0]) begin
          hit       = 1'b1;
          state_nxt = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (s2_zero) state_nxt = enable ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign load = hit && (!ts_valid || ts_ready);
  assign drop = hit && ts_valid && !ts_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      ts_valid   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (load) begin
        ts_q.coarse <= c2;
        ts_q.fine   <= fine;
        ts_valid    <= 1'b1;
      end else if (ts_ready) begin
        ts_valid    <= 1'b0;
      end
      if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  assign ts_data = ts_q;

endmodule
